// File: rtl/comb_decimator_if.sv
// Sample-stream bundle between the integrator cascade and the comb section.
// Signals:
//   i_en    input sample qualifier
//   i_data  signed accumulator sample from the integrators
//   o_data  signed decimated, differentiated sample (held between strobes)
//   o_valid one-cycle strobe marking a new o_data
// The master drives i_en/i_data and observes o_data/o_valid; the comb
// section itself uses the slave view.
interface comb_decimator_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic                         i_en;
    logic signed [DATA_WIDTH-1:0] i_data;
    logic signed [DATA_WIDTH-1:0] o_data;
    logic                         o_valid;

    modport master (
        output i_en,
        output i_data,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  i_en,
        input  i_data,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/comb_decimator.sv
// Decimating comb (differentiator) section of a CIC decimator.
// Keeps one of every DECIM enabled input samples and pushes each kept sample
// through STAGES pipelined first-difference stages (differential delay 1).
// All arithmetic wraps modulo 2^DATA_WIDTH; the integrator sizes the width.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous, active-high reset
//   bus    comb_decimator_if slave: i_en, i_data in; o_data, o_valid out
module comb_decimator #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned STAGES     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    comb_decimator_if.slave   bus
);

    // A one-bit counter is kept even for DECIM=1; it simply never leaves 0.
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]             r_cnt;
    logic signed [DATA_WIDTH-1:0] r_dec;
    logic                         r_dec_vld;

    // Per-stage delay register, output register and token.
    logic signed [DATA_WIDTH-1:0] r_d   [STAGES];
    logic signed [DATA_WIDTH-1:0] r_y   [STAGES];
    logic                         r_vld [STAGES];

    // Per-stage input word and incoming token.
    logic signed [DATA_WIDTH-1:0] stg_x_c   [STAGES];
    logic                         stg_tok_c [STAGES];

    logic cnt_last_c;
    logic keep_c;

    // Keep decision: the DECIM-th enabled sample of each group.
    always_comb begin
        cnt_last_c = (r_cnt == CNT_LAST);
        keep_c     = bus.i_en && cnt_last_c;
    end

    // Stage chaining: stage 0 is fed from the decimator register.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            stg_x_c[k]   = r_dec;
            stg_tok_c[k] = r_dec_vld;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            stg_x_c[k]   = r_y[k-1];
            stg_tok_c[k] = r_vld[k-1];
        end
    end

    // Decimation counter and kept-sample register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_dec     <= '0;
            r_dec_vld <= 1'b0;
        end else begin
            if (bus.i_en) begin
                r_cnt <= cnt_last_c ? '0 : CNT_W'(r_cnt + CNT_W'(1));
            end
            if (keep_c) begin
                r_dec <= bus.i_data;
            end
            r_dec_vld <= keep_c;
        end
    end

    // Comb stages: each token updates its stage once, then moves on a register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_d[k]   <= '0;
                r_y[k]   <= '0;
                r_vld[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (stg_tok_c[k]) begin
                    r_y[k] <= stg_x_c[k] - r_d[k];
                    r_d[k] <= stg_x_c[k];
                end
                r_vld[k] <= stg_tok_c[k];
            end
        end
    end

    assign bus.o_data  = r_y[STAGES-1];
    assign bus.o_valid = r_vld[STAGES-1];

endmodule

// File: doc/comb_decimator.md
# comb_decimator

Decimating comb (differentiator) section that closes the delta-sigma signal chain opposite the integrator. It accepts the wrapping accumulator stream from an integrator cascade, keeps one of every DECIM enabled samples, and runs each kept sample through STAGES pipelined first-difference stages. Integrator plus comb_decimator together form a CIC decimation filter; the output is a one-cycle-valid, reduced-rate sample stream.

## Interface
- DATA_WIDTH, 18: width of input, internal and output words; equals the integrator accumulator width.
- DECIM, 4: decimation ratio R; legal range is 1 or greater.
- STAGES, 2: number of comb stages N; legal range is 1 or greater; must equal the number of integrators in front.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_en  in  1  input sample qualifier; i_data is consumed only in cycles where i_en=1.
- i_data  in  DATA_WIDTH (signed)  accumulator sample from the integrator cascade.
- o_data  out  DATA_WIDTH (signed)  decimated, differentiated sample; holds its value between valid pulses.
- o_valid  out  1  one-cycle strobe marking a new o_data.

## Operation
- Decimation counter r_cnt, range 0..DECIM-1, increments on each i_en=1 cycle and wraps to 0 after DECIM-1.
  - A sample is kept when i_en=1 and r_cnt=DECIM-1 (the DECIM-th, 2·DECIM-th, … enabled sample).
  - With DECIM=1, every enabled sample is kept.
- A kept sample is registered into r_dec together with a valid token.
- Comb stage k (1..STAGES) has an input x_k and a delay register d_k.
  - On a cycle where its token arrives: y_k <= x_k - d_k and d_k <= x_k.
  - Otherwise y_k and d_k hold.
  - Differential delay is fixed at 1 decimated sample.
- Each stage passes its token forward one register per cycle. The last stage drives o_data and o_valid.
- Arithmetic is two's-complement modulo 2^DATA_WIDTH: no saturation, no bit growth, wrap is intentional.
  - Output is exact whenever the true CIC result (gain DECIM^STAGES) fits DATA_WIDTH.
  - Sizing the width for that is the integrator's responsibility.
- Tokens never collide, even with DECIM < STAGES+1: each stage handles at most one token per cycle, and tokens stay ordered.
- No backpressure. Consumers must take o_data in the o_valid cycle or from the held value before the next strobe.

## Timing
- Reset (i_rst=1 at an edge) clears r_cnt, r_dec, all d_k and y_k, all tokens, o_data and o_valid to 0.
  - i_rst has priority over i_en in the same cycle; that sample is dropped.
  - A reset mid-operation discards in-flight tokens.
  - o_valid is 0 in the cycle after the reset edge.
- Latency: a kept sample presented in cycle 0 is captured at the end of cycle 0.
  - It leaves stage k at the end of cycle k.
  - o_valid=1 with the new o_data in cycle STAGES+1 (cycle 3 for defaults).
- o_valid is high for exactly one cycle per kept sample.
  - With i_en held high, pulses are spaced DECIM cycles apart.
  - With gaps in i_en, pulses are spaced DECIM enabled samples apart.
- Start-up transient: the first STAGES outputs after reset are computed against zeroed delay registers. They are valid strobes but not settled values.
- Idle i_en=0 for any length: no state changes except token propagation; r_cnt position is kept.

## Test plan
- Reset: hold i_rst=1 for 3 cycles with random i_data and i_en=1 → o_data=0 and o_valid=0 throughout and in the first cycle after release.
- CIC gain, defaults: drive i_data = (n+1)(n+2)/2 for n=0,1,2,… with i_en=1 every cycle (a double-integrated constant 1).
  - Kept samples are 10, 36, 78, 136.
  - o_data must be 10, 16, 16, 16, with o_valid every 4 cycles.
- Latency: after reset, pulse i_en on 4 consecutive cycles with i_data=5 on the 4th → o_valid high exactly in cycle 3 counted from that 4th cycle, with o_data=5.
- Enable gaps: repeat the CIC gain test with i_en=1 only on alternate cycles → identical o_data sequence 10, 16, 16, 16, with o_valid spacing 8 cycles.
- Wrap-around: STAGES=1 instance, ramp i_data from 130000 in steps of 1000, crossing +131071 into negative values → every settled o_data = 4000, with no glitch at the wrap.
- Reset mid-stream: in the CIC gain test, assert i_rst for one cycle while r_cnt=2 and one token is in flight.
  - o_valid=0 next cycle and the in-flight output is never produced.
  - Restarting the sequence from n=0 yields 10, 16, 16, 16 again.
